csm_arbiter: RTL and testbench

Dual-port shared-memory controller for the CSM design: processors A and B each issue hold/release/read/write transactions over a multiplexed address/data bus, and the block services them against a common 2^DATABITS-entry array. It enforces an exclusive lock: a port that has been granted a hold blocks the other port's accesses. The block is the device directly downstream of the per-processor bus drivers.

---
 rtl/csm_pkg.sv | 24 ++
 rtl/csm_port_fsm.sv | 91 +++++++++
 rtl/csm_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_csm_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/csm_pkg.sv
// Shared types for the CSM dual-port shared-memory controller.
package csm_pkg;

   typedef enum logic [1:0] {
      ERR_OK        = 2'b00,
      ERR_LOCKED    = 2'b01,
      ERR_LOCKFAULT = 2'b10,
      ERR_COLLIDE   = 2'b11
   } err_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      LOCK = 2'b11
   } port_state_t;

   typedef enum logic [1:0] {
      NONE  = 2'b00,
      OWN_A = 2'b01,
      OWN_B = 2'b10
   } owner_t;

endpackage

// File: rtl/csm_port_fsm.sv
// Per-port command FSM: decodes a strobe in IDLE, holds the address and lock op,
// and registers ack/err/out_data when the command completes one cycle later.
module csm_port_fsm
   import csm_pkg::*;
#(
   parameter int DATABITS = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [DATABITS-1:0] in_ad_i,
   input  logic                rw_i,
   input  logic                enable_i,
   input  logic                hold_i,
   input  logic                release_i,
   input  err_t                done_err_i,
   input  logic                rd_ok_i,
   input  logic [DATABITS-1:0] rd_data_i,
   output port_state_t         state_o,
   output logic [DATABITS-1:0] addr_o,
   output logic                hold_o,
   output logic                release_o,
   output logic                ack_o,
   output err_t                err_o,
   output logic [DATABITS-1:0] out_data_o
);

   port_state_t         state_q, state_d;
   logic                ack_q, ack_d;
   err_t                err_q, err_d;
   logic [DATABITS-1:0] data_q, data_d;
   logic [DATABITS-1:0] addr_q, addr_d;
   logic                hold_q, hold_d;
   logic                rel_q, rel_d;

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      data_d  = data_q;
      addr_d  = addr_q;
      hold_d  = hold_q;
      rel_d   = rel_q;
      case (state_q)
         IDLE: begin
            if (enable_i) begin
               addr_d = in_ad_i;
               hold_d = hold_i;
               rel_d  = release_i;
               if (hold_i || release_i) state_d = LOCK;
               else if (rw_i)           state_d = WR;
               else                     state_d = RD;
            end
         end
         default: begin
            state_d = IDLE;
            err_d   = done_err_i;
            if (state_q == RD && rd_ok_i) data_d = rd_data_i;
         end
      endcase
      ack_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ack_q   <= 1'b1;
         err_q   <= ERR_OK;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         data_q  <= data_d;
      end
   end

   // Command operands only matter outside IDLE, so they carry no reset.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      hold_q <= hold_d;
      rel_q  <= rel_d;
   end

   assign state_o    = state_q;
   assign addr_o     = addr_q;
   assign hold_o     = hold_q;
   assign release_o  = rel_q;
   assign ack_o      = ack_q;
   assign err_o      = err_q;
   assign out_data_o = data_q;

endmodule

// File: rtl/csm_arbiter.sv
// Dual-port shared-memory controller with exclusive hold/release lock.
// Optional lock auto-release is built only when CSM_LOCK_TIMEOUT_EN is defined.
module csm_arbiter
   import csm_pkg::*;
#(
   parameter int DATABITS     = 8,
   parameter int ERRBITS      = 2,
   parameter int LOCK_TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [DATABITS-1:0] A_in_AD,
   input  logic                A_rw,
   input  logic                A_enable,
   input  logic                A_hold,
   input  logic                A_release,
   output logic                A_ack,
   output logic [ERRBITS-1:0]  A_err,
   output logic [DATABITS-1:0] A_out_data,
   input  logic [DATABITS-1:0] B_in_AD,
   input  logic                B_rw,
   input  logic                B_enable,
   input  logic                B_hold,
   input  logic                B_release,
   output logic                B_ack,
   output logic [ERRBITS-1:0]  B_err,
   output logic [DATABITS-1:0] B_out_data
);

   logic [DATABITS-1:0] mem_q [2**DATABITS];

   owner_t              owner_q, own_mid, own_d;
   port_state_t         a_state, b_state;
   logic [DATABITS-1:0] a_addr, b_addr;
   logic                a_hold, a_rel, b_hold, b_rel;
   logic                a_we, b_we, a_rok, b_rok;
   err_t                a_res, b_res, a_fin, b_fin, a_err, b_err;
   logic                expire;

   csm_port_fsm #(.DATABITS(DATABITS)) u_fsm_a (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_ad_i    (A_in_AD),
      .rw_i       (A_rw),
      .enable_i   (A_enable),
      .hold_i     (A_hold),
      .release_i  (A_release),
      .done_err_i (a_fin),
      .rd_ok_i    (a_rok),
      .rd_data_i  (mem_q[a_addr]),
      .state_o    (a_state),
      .addr_o     (a_addr),
      .hold_o     (a_hold),
      .release_o  (a_rel),
      .ack_o      (A_ack),
      .err_o      (a_err),
      .out_data_o (A_out_data)
   );

   csm_port_fsm #(.DATABITS(DATABITS)) u_fsm_b (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_ad_i    (B_in_AD),
      .rw_i       (B_rw),
      .enable_i   (B_enable),
      .hold_i     (B_hold),
      .release_i  (B_release),
      .done_err_i (b_fin),
      .rd_ok_i    (b_rok),
      .rd_data_i  (mem_q[b_addr]),
      .state_o    (b_state),
      .addr_o     (b_addr),
      .hold_o     (b_hold),
      .release_o  (b_rel),
      .ack_o      (B_ack),
      .err_o      (b_err),
      .out_data_o (B_out_data)
   );

   assign A_err = ERRBITS'(a_err);
   assign B_err = ERRBITS'(b_err);

   // Lock ops resolve A first, then B against A's outcome, so a tie goes to A.
   always_comb begin
      own_mid = owner_q;
      own_d   = owner_q;
      a_res   = ERR_OK;
      b_res   = ERR_OK;
      a_we    = 1'b0;
      b_we    = 1'b0;
      a_rok   = 1'b0;
      b_rok   = 1'b0;
      case (a_state)
         RD: if (owner_q == OWN_B) a_res = ERR_LOCKED; else a_rok = 1'b1;
         WR: if (owner_q == OWN_B) a_res = ERR_LOCKED; else a_we = 1'b1;
         LOCK: begin
            if (a_hold && a_rel)      a_res = ERR_LOCKFAULT;
            else if (a_hold) begin
               if (owner_q == OWN_B)  a_res = ERR_LOCKFAULT;
               else                   own_mid = OWN_A;
            end
            else if (owner_q == OWN_A) own_mid = NONE;
            else                      a_res = ERR_LOCKFAULT;
         end
         default: ;
      endcase
      own_d = own_mid;
      case (b_state)
         RD: if (owner_q == OWN_A) b_res = ERR_LOCKED; else b_rok = 1'b1;
         WR: begin
            if (owner_q == OWN_A)                b_res = ERR_LOCKED;
            else if (a_we && (a_addr == b_addr)) b_res = ERR_COLLIDE;
            else                                 b_we  = 1'b1;
         end
         LOCK: begin
            if (b_hold && b_rel)      b_res = ERR_LOCKFAULT;
            else if (b_hold) begin
               if (own_mid == OWN_A)  b_res = ERR_LOCKFAULT;
               else                   own_d = OWN_B;
            end
            else if (own_mid == OWN_B) own_d = NONE;
            else                      b_res = ERR_LOCKFAULT;
         end
         default: ;
      endcase
   end

`ifdef CSM_LOCK_TIMEOUT_EN
   localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             to_a_q, to_a_d, to_b_q, to_b_d;
   logic             counting;

   always_comb begin
      counting = ((owner_q == OWN_A) && (a_state == IDLE) && !A_enable) ||
                 ((owner_q == OWN_B) && (b_state == IDLE) && !B_enable);
      expire   = counting && (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));
      cnt_d    = (counting && !expire) ? cnt_q + 1'b1 : '0;
      to_a_d   = to_a_q;
      to_b_d   = to_b_q;
      if (a_state != IDLE) to_a_d = 1'b0;
      if (b_state != IDLE) to_b_d = 1'b0;
      if (expire && owner_q == OWN_A) to_a_d = 1'b1;
      if (expire && owner_q == OWN_B) to_b_d = 1'b1;
      a_fin = (to_a_q && a_state != IDLE) ? ERR_LOCKFAULT : a_res;
      b_fin = (to_b_q && b_state != IDLE) ? ERR_LOCKFAULT : b_res;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         to_a_q <= 1'b0;
         to_b_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         to_a_q <= to_a_d;
         to_b_q <= to_b_d;
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = (LOCK_TIMEOUT != 0);
   assign expire         = 1'b0;
   assign a_fin          = a_res;
   assign b_fin          = b_res;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) owner_q <= NONE;
      else          owner_q <= expire ? NONE : own_d;
   end

   // Write data is taken from the bus in the completion cycle; A wins a same-address tie.
   always_ff @(posedge clk) begin
      if (a_we) mem_q[a_addr] <= A_in_AD;
      if (b_we) mem_q[b_addr] <= B_in_AD;
   end

endmodule

// File: tb/tb_csm_arbiter.sv
// Directed self-checking bench for csm_arbiter; timeout expectations follow CSM_LOCK_TIMEOUT_EN.
module tb_csm_arbiter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] A_in_AD, B_in_AD;
   logic       A_rw, A_enable, A_hold, A_release;
   logic       B_rw, B_enable, B_hold, B_release;
   logic       A_ack, B_ack;
   logic [1:0] A_err, B_err;
   logic [7:0] A_out_data, B_out_data;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   csm_arbiter #(.DATABITS(8), .ERRBITS(2), .LOCK_TIMEOUT(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .A_in_AD    (A_in_AD),
      .A_rw       (A_rw),
      .A_enable   (A_enable),
      .A_hold     (A_hold),
      .A_release  (A_release),
      .A_ack      (A_ack),
      .A_err      (A_err),
      .A_out_data (A_out_data),
      .B_in_AD    (B_in_AD),
      .B_rw       (B_rw),
      .B_enable   (B_enable),
      .B_hold     (B_hold),
      .B_release  (B_release),
      .B_ack      (B_ack),
      .B_err      (B_err),
      .B_out_data (B_out_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One command slot for both ports: command cycle then data/completion cycle.
   task automatic run2(input logic ae, input logic ah, input logic ar, input logic arw,
                       input logic [7:0] aa, input logic [7:0] ad,
                       input logic be, input logic bh, input logic br, input logic brw,
                       input logic [7:0] ba, input logic [7:0] bd);
      @(negedge clk);
      A_enable = ae; A_hold = ah; A_release = ar; A_rw = arw; A_in_AD = aa;
      B_enable = be; B_hold = bh; B_release = br; B_rw = brw; B_in_AD = ba;
      @(posedge clk); #1;
      chk("A_ack_busy", A_ack, !ae);
      chk("B_ack_busy", B_ack, !be);
      @(negedge clk);
      A_enable = 0; A_hold = 0; A_release = 0; A_in_AD = ad;
      B_enable = 0; B_hold = 0; B_release = 0; B_in_AD = bd;
      @(posedge clk); #1;
      chk("A_ack_done", A_ack, 1);
      chk("B_ack_done", B_ack, 1);
   endtask

   task automatic a_cmd(input logic h, input logic r, input logic rw, input logic [7:0] a, input logic [7:0] d);
      run2(1, h, r, rw, a, d, 0, 0, 0, 0, 8'h00, 8'h00);
   endtask

   task automatic b_cmd(input logic h, input logic r, input logic rw, input logic [7:0] a, input logic [7:0] d);
      run2(0, 0, 0, 0, 8'h00, 8'h00, 1, h, r, rw, a, d);
   endtask

   initial begin
      reset_n = 0;
      A_in_AD = 0; A_rw = 0; A_enable = 0; A_hold = 0; A_release = 0;
      B_in_AD = 0; B_rw = 0; B_enable = 0; B_hold = 0; B_release = 0;
      #22;
      chk("rst_A_ack", A_ack, 1);
      chk("rst_B_ack", B_ack, 1);
      chk("rst_A_err", A_err, 0);
      chk("rst_B_err", B_err, 0);
      chk("rst_A_data", A_out_data, 0);
      chk("rst_B_data", B_out_data, 0);
      @(negedge clk); reset_n = 1;

      // basic write then read across ports
      a_cmd(0, 0, 1, 8'h10, 8'hA5);
      chk("wr10_A_err", A_err, 0);
      b_cmd(0, 0, 0, 8'h10, 8'h00);
      chk("rd10_B_data", B_out_data, 8'hA5);
      chk("rd10_B_err", B_err, 0);

      // lockout by A's hold
      a_cmd(0, 0, 1, 8'h20, 8'h77);
      a_cmd(1, 0, 0, 8'h00, 8'h00);
      chk("holdA_err", A_err, 0);
      b_cmd(0, 0, 1, 8'h20, 8'h11);
      chk("lockedwr_B_err", B_err, 1);
      b_cmd(0, 0, 0, 8'h20, 8'h00);
      chk("lockedrd_B_err", B_err, 1);
      chk("lockedrd_B_data", B_out_data, 8'hA5);
      a_cmd(0, 0, 0, 8'h20, 8'h00);
      chk("owner_rd20_A", A_out_data, 8'h77);
      chk("owner_rd20_err", A_err, 0);
      a_cmd(0, 1, 0, 8'h00, 8'h00);
      chk("relA_err", A_err, 0);
      b_cmd(0, 0, 1, 8'h20, 8'h11);
      chk("wr20_B_err", B_err, 0);
      b_cmd(0, 0, 0, 8'h20, 8'h00);
      chk("rd20_B_data", B_out_data, 8'h11);

      // simultaneous holds: A wins
      run2(1, 1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 8'h00, 8'h00);
      chk("dualhold_A_err", A_err, 0);
      chk("dualhold_B_err", B_err, 2);
      b_cmd(0, 1, 0, 8'h00, 8'h00);
      chk("relB_nonowner", B_err, 2);
      run2(1, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
      chk("holdrel_A_err", A_err, 2);
      a_cmd(0, 1, 0, 8'h00, 8'h00);
      chk("relA2_err", A_err, 0);

      // same-address write collision
      run2(1, 0, 0, 1, 8'h30, 8'h01, 1, 0, 0, 1, 8'h30, 8'h02);
      chk("coll_A_err", A_err, 0);
      chk("coll_B_err", B_err, 3);
      a_cmd(0, 0, 0, 8'h30, 8'h00);
      chk("coll_rd30", A_out_data, 8'h01);

      // parallel reads, then read/write same address
      run2(1, 0, 0, 0, 8'h10, 8'h00, 1, 0, 0, 0, 8'h30, 8'h00);
      chk("par_A_data", A_out_data, 8'hA5);
      chk("par_B_data", B_out_data, 8'h01);
      run2(1, 0, 0, 0, 8'h30, 8'h00, 1, 0, 0, 1, 8'h30, 8'h55);
      chk("rw_A_old", A_out_data, 8'h01);
      chk("rw_B_err", B_err, 0);
      b_cmd(0, 0, 0, 8'h30, 8'h00);
      chk("rw_B_new", B_out_data, 8'h55);

      // reset in the middle of a write
      a_cmd(1, 0, 0, 8'h00, 8'h00);
      a_cmd(0, 0, 1, 8'h40, 8'h33);
      chk("wr40_A_err", A_err, 0);
      @(negedge clk);
      A_enable = 1; A_rw = 1; A_in_AD = 8'h40;
      @(posedge clk); #1;
      chk("rstwr_busy", A_ack, 0);
      @(negedge clk);
      A_enable = 0; A_in_AD = 8'h99; reset_n = 0;
      #1;
      chk("rstwr_ack", A_ack, 1);
      chk("rstwr_data", A_out_data, 0);
      @(posedge clk);
      @(negedge clk); reset_n = 1;
      b_cmd(0, 0, 1, 8'h41, 8'h5A);
      chk("rst_owner_none", B_err, 0);
      a_cmd(0, 0, 0, 8'h40, 8'h00);
      chk("rst_nocommit", A_out_data, 8'h33);

      // idle held lock: auto-release only in the timeout build
      a_cmd(1, 0, 0, 8'h00, 8'h00);
      chk("to_hold_err", A_err, 0);
      repeat (9) @(posedge clk);
      b_cmd(0, 0, 1, 8'h50, 8'h66);
`ifdef CSM_LOCK_TIMEOUT_EN
      chk("to_B_wr", B_err, 0);
      a_cmd(0, 0, 0, 8'h50, 8'h00);
      chk("to_A_fault", A_err, 2);
      a_cmd(0, 0, 0, 8'h50, 8'h00);
      chk("to_A_once", A_err, 0);
      chk("to_A_data", A_out_data, 8'h66);
`else
      chk("to_B_locked", B_err, 1);
      a_cmd(0, 0, 0, 8'h10, 8'h00);
      chk("to_A_err", A_err, 0);
      chk("to_A_data", A_out_data, 8'hA5);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
